uart_frame_parser: RTL

// Consumes the byte stream from the UART receiver (8-bit data + 1-cycle done strobe).

---
 rtl/uart_frame_parser_if.sv | 20 ++
 rtl/uart_frame_parser.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream bundle between uart_rx, the frame parser and the command decoder.
// Carries the receive strobe side and the valid/ready payload replay side.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output rx_data, rx_done, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  rx_data, rx_done, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser: SYNC, LEN, PAYLOAD[LEN], CHK from a UART byte stream.
// Good payloads are buffered and replayed on a valid/ready stream with last.
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    uart_frame_parser_if.slave  bus,
    output logic                frame_ok,
    output logic                frame_err,
    output logic [7:0]          drop_cnt
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        HUNT, LEN, PAYLOAD, CHK, SEND
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      rd_q, rd_d;
    logic [7:0]      sum_q, sum_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ok_q, ok_d;
    logic            err_q, err_d;
    logic [7:0]      drop_q, drop_d;
    logic            wr_en;
    logic            timed;
    logic            hs;
    logic            last;
    logic [7:0]      mem_q [2**AW];

    assign timed = (state_q == LEN) || (state_q == PAYLOAD) ||
                   (state_q == CHK);
    assign last  = (rd_q == len_q - 8'd1);
    assign hs    = (state_q == SEND) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        sum_d   = sum_q;
        drop_d  = drop_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        timer_d = '0;
        if (timed && !bus.rx_done)
            timer_d = timer_q + TW'(1);
        unique case (state_q)
            HUNT: begin
                if (bus.rx_done && bus.rx_data == SYNC_BYTE)
                    state_d = LEN;
            end
            LEN: begin
                if (bus.rx_done) begin
                    len_d = bus.rx_data;
                    sum_d = bus.rx_data;
                    idx_d = 8'd0;
                    if (bus.rx_data > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (bus.rx_data == 8'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_done) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + bus.rx_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q + 8'd1 == len_q)
                        state_d = CHK;
                end
            end
            CHK: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == sum_q) begin
                        ok_d    = 1'b1;
                        rd_d    = 8'd0;
                        state_d = (len_q == 8'd0) ? HUNT : SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            SEND: begin
                if (bus.rx_done && drop_q != 8'hFF)
                    drop_d = drop_q + 8'd1;
                if (hs) begin
                    rd_d = rd_q + 8'd1;
                    if (last)
                        state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (timed && !bus.rx_done && timer_q == TW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            sum_q   <= sum_d;
            timer_q <= timer_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[idx_q[AW-1:0]] <= bus.rx_data;
    end

    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = bus.out_valid ? mem_q[rd_q[AW-1:0]] : 8'd0;
    assign bus.out_last  = bus.out_valid && last;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign drop_cnt      = drop_q;
endmodule
